i2s_receiver: RTL and testbench

- I2S (Philips format) receiver for the audio peripheral, capturing stereo samples from an external ADC.
- Oversamples I2S_CLK, I2S_WS and I2S_DATA in the MasterCLK (100 MHz) domain and deserialises left/right words MSB-first.
- Presents each frame as one packed word whose layout matches the 32-bit DAC-path data word, plus a one-cycle valid strobe.

---
 rtl/i2s_receiver_if.sv | 35 +++
 rtl/i2s_receiver.sv | 163 ++++++++++++++++
 tb/tb_i2s_receiver.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - I2S serial bus and deserialised frame outputs
//
// Purpose: bundles the ADC-side serial pins with the frame outputs that the
//          receiver hands to the audio peripheral.
// Signals:
//   I2S_CLK    serial bit clock from the ADC (asynchronous)
//   I2S_WS     word select, 0 = left, 1 = right
//   I2S_DATA   serial data, MSB first, valid on the I2S_CLK rising edge
//   OutputData {left, right}, left in the upper half
//   DataValid  one-cycle pulse when OutputData updates
//   FrameError one-cycle pulse with DataValid when a slot length was wrong
//   Locked     high while aligned to the frame
// Modports: master = ADC/stimulus side, slave = receiver side.

interface i2s_receiver_if #(
  parameter int SampleBits = 16
);
  logic                    I2S_CLK;
  logic                    I2S_WS;
  logic                    I2S_DATA;
  logic [2*SampleBits-1:0] OutputData;
  logic                    DataValid;
  logic                    FrameError;
  logic                    Locked;

  modport master (
    output I2S_CLK, I2S_WS, I2S_DATA,
    input  OutputData, DataValid, FrameError, Locked
  );

  modport slave (
    input  I2S_CLK, I2S_WS, I2S_DATA,
    output OutputData, DataValid, FrameError, Locked
  );
endinterface

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - Philips-format I2S stereo receiver
//
// Purpose: oversamples the I2S pins in the MasterCLK domain, aligns to the
//          frame on a WS 1->0 transition and deserialises left/right words
//          MSB-first into one packed {left, right} word with a valid strobe.
// Ports:
//   MasterCLK  system clock, all logic on its rising edge
//   Reset      asynchronous, active-low reset
//   bus        i2s_receiver_if.slave (serial pins in, frame outputs out)

module i2s_receiver #(
  parameter int SampleBits    = 16,
  parameter int TimeoutCycles = 256
) (
  input  logic           MasterCLK,
  input  logic           Reset,
  i2s_receiver_if.slave  bus
);
  localparam int CW = $clog2(SampleBits + 2);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] CntFull = CW'(SampleBits);
  localparam logic [CW-1:0] CntSat  = CW'(SampleBits + 1);
  localparam logic [TW-1:0] ToLast  = TW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {S_HUNT, S_ALIGN, S_LEFT, S_RIGHT} state_t;
  state_t r_state, w_next_state;

  // SCK needs a third stage for edge detection; WS/DATA are taken from
  // stage2, so their third stage would carry nothing and is not built.
  logic [2:0] r_sck_sync;
  logic [1:0] r_ws_sync, r_dat_sync;
  logic       w_sck_rise;

  // Edge, WS and data registered together so every edge is seen once.
  logic r_edge, r_ws_now, r_bit, r_ws_prev;
  logic w_ws_fall, w_ws_rise, w_timeout;

  logic [TW-1:0]           r_to_cnt;
  logic [SampleBits-1:0]   r_left, r_right, w_left_ins, w_right_ins;
  logic [CW-1:0]           r_lcnt, r_rcnt, w_lcnt_inc, w_rcnt_inc;
  logic                    r_left_err, w_left_err, w_right_err;
  logic [2*SampleBits-1:0] r_frame, r_out;
  logic                    r_frame_err, r_emit, r_valid, r_ferr;

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_ws_fall  = r_edge &  r_ws_prev & ~r_ws_now;
  assign w_ws_rise  = r_edge & ~r_ws_prev &  r_ws_now;
  assign w_timeout  = ~r_edge & (r_to_cnt == ToLast);

  assign bus.OutputData = r_out;
  assign bus.DataValid  = r_valid;
  assign bus.FrameError = r_ferr;
  assign bus.Locked     = (r_state == S_LEFT) || (r_state == S_RIGHT);

  // Bit insertion at position SampleBits-1-cnt; counts past the word match
  // no position, so surplus bits fall away.
  always_comb begin
    w_left_ins  = r_left;
    w_right_ins = r_right;
    for (int i = 0; i < SampleBits; i++) begin
      if (r_lcnt == CW'(SampleBits - 1 - i)) w_left_ins[i]  = r_bit;
      if (r_rcnt == CW'(SampleBits - 1 - i)) w_right_ins[i] = r_bit;
    end
    w_lcnt_inc  = (r_lcnt == CntSat) ? r_lcnt : r_lcnt + CW'(1);
    w_rcnt_inc  = (r_rcnt == CntSat) ? r_rcnt : r_rcnt + CW'(1);
    // Slot length includes the closing bit.
    w_left_err  = (w_lcnt_inc != CntFull);
    w_right_err = (w_rcnt_inc != CntFull);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HUNT:  if (r_edge)    w_next_state = S_ALIGN;
      S_ALIGN: if (w_ws_fall) w_next_state = S_LEFT;
      S_LEFT:  if (w_ws_rise) w_next_state = S_RIGHT;
      S_RIGHT: if (w_ws_fall) w_next_state = S_LEFT;
      default:                w_next_state = S_HUNT;
    endcase
    if (w_timeout) w_next_state = S_HUNT;
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) r_state <= S_HUNT;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_sck_sync  <= '0;
      r_ws_sync   <= '0;
      r_dat_sync  <= '0;
      r_edge      <= 1'b0;
      r_ws_now    <= 1'b0;
      r_bit       <= 1'b0;
      r_ws_prev   <= 1'b0;
      r_to_cnt    <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_lcnt      <= '0;
      r_rcnt      <= '0;
      r_left_err  <= 1'b0;
      r_frame     <= '0;
      r_frame_err <= 1'b0;
      r_emit      <= 1'b0;
      r_out       <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], bus.I2S_CLK};
      r_ws_sync  <= {r_ws_sync[0], bus.I2S_WS};
      r_dat_sync <= {r_dat_sync[0], bus.I2S_DATA};
      r_edge     <= w_sck_rise;
      r_ws_now   <= r_ws_sync[1];
      r_bit      <= r_dat_sync[1];

      if (r_edge)               r_to_cnt <= '0;
      else if (r_to_cnt != ToLast) r_to_cnt <= r_to_cnt + TW'(1);

      // Output stage: one cycle behind the closing edge.
      r_emit  <= 1'b0;
      r_valid <= r_emit;
      r_ferr  <= r_emit & r_frame_err;
      if (r_emit) r_out <= r_frame;

      if (r_edge) begin
        r_ws_prev <= r_ws_now;
        case (r_state)
          S_ALIGN: begin
            if (w_ws_fall) begin
              r_left     <= '0;
              r_lcnt     <= '0;
              r_left_err <= 1'b0;
            end
          end
          S_LEFT: begin
            r_left <= w_left_ins;
            r_lcnt <= w_lcnt_inc;
            if (w_ws_rise) begin
              r_left_err <= w_left_err;
              r_right    <= '0;
              r_rcnt     <= '0;
            end
          end
          S_RIGHT: begin
            r_right <= w_right_ins;
            r_rcnt  <= w_rcnt_inc;
            if (w_ws_fall) begin
              // Snapshot the frame so the left word can restart at once.
              r_frame     <= {r_left, w_right_ins};
              r_frame_err <= r_left_err | w_right_err;
              r_emit      <= 1'b1;
              r_left      <= '0;
              r_lcnt      <= '0;
              r_left_err  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - directed-vector bench for i2s_receiver

module tb_i2s_receiver;
  localparam int SB = 16;

  logic MasterCLK = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_close = 0;
  int   sck_half = 20;

  bit          q_ch[$];
  bit          q_bit[$];
  logic [31:0] dv_data[$];
  logic [31:0] dv_err[$];
  logic [31:0] dv_lat[$];

  i2s_receiver_if #(.SampleBits(SB)) bus ();

  i2s_receiver #(.SampleBits(SB), .TimeoutCycles(256)) dut (
    .MasterCLK (MasterCLK),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 MasterCLK = ~MasterCLK;

  always @(posedge MasterCLK) cyc <= cyc + 1;

  // Every high cycle of DataValid is logged, so the log length also
  // measures pulse width.
  always @(negedge MasterCLK) begin
    if (bus.DataValid === 1'b1) begin
      dv_data.push_back(bus.OutputData);
      dv_err.push_back({31'd0, bus.FrameError});
      dv_lat.push_back(cyc - last_close);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dv_d(input int i);
    if (i < dv_data.size()) return dv_data[i];
    return 'x;
  endfunction

  function automatic logic [31:0] dv_e(input int i);
    if (i < dv_err.size()) return dv_err[i];
    return 'x;
  endfunction

  function automatic logic [31:0] dv_l(input int i);
    if (i < dv_lat.size()) return dv_lat[i];
    return 'x;
  endfunction

  task automatic clear_mon();
    dv_data.delete();
    dv_err.delete();
    dv_lat.delete();
  endtask

  task automatic push_word(input bit ch, input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      q_ch.push_back(ch);
      q_bit.push_back(v[i]);
    end
  endtask

  // One SCK period per queued bit; WS leads the data by one bit (Philips).
  task automatic play(input int n);
    bit ch, b, ws;
    for (int k = 0; k < n && q_ch.size() > 0; k++) begin
      ch = q_ch.pop_front();
      b  = q_bit.pop_front();
      ws = (q_ch.size() > 0) ? q_ch[0] : ch;
      @(negedge MasterCLK);
      bus.I2S_CLK  = 1'b0;
      bus.I2S_WS   = ws;
      bus.I2S_DATA = b;
      repeat (sck_half) @(negedge MasterCLK);
      bus.I2S_CLK = 1'b1;
      if (ch && !ws) last_close = cyc + 1;
      repeat (sck_half) @(negedge MasterCLK);
    end
  endtask

  task automatic play_all();
    play(q_ch.size());
  endtask

  task automatic idle(input int n);
    @(negedge MasterCLK);
    bus.I2S_CLK = 1'b0;
    repeat (n) @(negedge MasterCLK);
  endtask

  initial begin
    Reset        = 1'b0;
    bus.I2S_CLK  = 1'b0;
    bus.I2S_WS   = 1'b0;
    bus.I2S_DATA = 1'b0;

    // Reset held while the bus toggles.
    push_word(1'b0, 16, 32'h0000FFFF);
    push_word(1'b1, 16, 32'h0000AAAA);
    play(20);
    check("rst_data",   bus.OutputData, 32'h0);
    check("rst_valid",  bus.DataValid,  32'h0);
    check("rst_ferr",   bus.FrameError, 32'h0);
    check("rst_locked", bus.Locked,     32'h0);
    q_ch.delete();
    q_bit.delete();
    idle(5);
    Reset = 1'b1;
    clear_mon();

    // Nominal 16-bit frames after one alignment slot.
    push_word(1'b1, 16, 32'h0000FFFF);
    push_word(1'b0, 16, 32'h0000A5C3);
    push_word(1'b1, 16, 32'h00001234);
    push_word(1'b0, 16, 32'h00005A3C);
    push_word(1'b1, 16, 32'h0000FEDC);
    push_word(1'b0, 16, 32'h00000000);
    play(10);
    check("lock_hunt", bus.Locked, 32'h0);
    play(7);
    check("lock_fall", bus.Locked, 32'h1);
    play_all();
    idle(20);
    check("nom_count", dv_data.size(), 32'd2);
    check("nom_data0", dv_d(0), 32'hA5C31234);
    check("nom_ferr0", dv_e(0), 32'h0);
    check("nom_lat0",  dv_l(0), 32'd4);
    check("nom_data1", dv_d(1), 32'h5A3CFEDC);
    check("nom_ferr1", dv_e(1), 32'h0);
    check("nom_hold",  bus.OutputData, 32'h5A3CFEDC);
    idle(300);
    check("nom_unlock", bus.Locked, 32'h0);

    // Reset released 5 bits into a right slot.
    @(negedge MasterCLK);
    Reset = 1'b0;
    clear_mon();
    push_word(1'b0, 16, 32'h0000DEAD);
    push_word(1'b1, 16, 32'h0000FFFF);
    push_word(1'b0, 16, 32'h00000001);
    push_word(1'b1, 16, 32'h00008000);
    push_word(1'b0, 16, 32'h00000000);
    play(21);
    Reset = 1'b1;
    play_all();
    idle(20);
    check("mid_count", dv_data.size(), 32'd1);
    check("mid_data",  dv_d(0), 32'h00018000);
    check("mid_ferr",  dv_e(0), 32'h0);
    idle(300);

    // 24-bit slots: truncated words, slot error.
    clear_mon();
    push_word(1'b1, 24, 32'h0);
    push_word(1'b0, 24, 32'h00ABCDEF);
    push_word(1'b1, 24, 32'h00123456);
    push_word(1'b0, 24, 32'h0);
    play_all();
    idle(20);
    check("long_count", dv_data.size(), 32'd1);
    check("long_data",  dv_d(0), 32'hABCD1234);
    check("long_ferr",  dv_e(0), 32'h1);
    idle(300);

    // 12-bit slots: zero-filled LSBs, slot error.
    clear_mon();
    push_word(1'b1, 12, 32'h0);
    push_word(1'b0, 12, 32'h00000FFF);
    push_word(1'b1, 12, 32'h00000800);
    push_word(1'b0, 12, 32'h0);
    play_all();
    idle(20);
    check("short_count", dv_data.size(), 32'd1);
    check("short_data",  dv_d(0), 32'hFFF08000);
    check("short_ferr",  dv_e(0), 32'h1);
    idle(300);

    // SCK stalls mid-left; realignment needed after resuming.
    clear_mon();
    push_word(1'b1, 16, 32'h0);
    push_word(1'b0, 16, 32'h00001111);
    push_word(1'b1, 16, 32'h00002222);
    push_word(1'b0, 16, 32'h00000F0F);
    push_word(1'b1, 16, 32'h0000F0F0);
    push_word(1'b0, 16, 32'h0);
    play(24);
    idle(200);
    check("stall_locked", bus.Locked, 32'h1);
    idle(60);
    check("stall_unlock", bus.Locked, 32'h0);
    check("stall_noemit", dv_data.size(), 32'd0);
    play_all();
    idle(20);
    check("resume_count", dv_data.size(), 32'd1);
    check("resume_data",  dv_d(0), 32'h0F0FF0F0);
    idle(300);

    // Asynchronous reset in the middle of a right slot.
    clear_mon();
    push_word(1'b1, 16, 32'h0);
    push_word(1'b0, 16, 32'h0000AAAA);
    push_word(1'b1, 16, 32'h00005555);
    push_word(1'b0, 16, 32'h00001234);
    push_word(1'b1, 16, 32'h00005678);
    push_word(1'b0, 16, 32'h0);
    play(49);
    idle(10);
    check("arst_pre_data", bus.OutputData, 32'hAAAA5555);
    play(23);
    check("arst_pre_lock", bus.Locked, 32'h1);
    @(negedge MasterCLK);
    #2 Reset = 1'b0;
    #1;
    check("arst_data",   bus.OutputData, 32'h0);
    check("arst_locked", bus.Locked,     32'h0);
    check("arst_valid",  bus.DataValid,  32'h0);
    q_ch.delete();
    q_bit.delete();
    idle(5);
    Reset = 1'b1;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
